// File: rtl/ex_muldiv_ctrl.sv
// Iterative radix-2 multiply/divide sequencer for the EX stage.
// Handshake: start is a level held by EX while stall_req is high; result_valid is a one-cycle strobe.
module ex_muldiv_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_W-1:0]     src_a,
  input  logic [DATA_W-1:0]     src_b,
  input  logic                  flush,
  output logic                  stall_req,
  output logic                  busy,
  output logic                  result_valid,
  output logic [2*DATA_W-1:0]   result
);
  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state, next_state;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   acc_hi, acc_lo, opnd_b;
  logic                is_div, sign_q, sign_r;

  logic                signed_op, a_neg, b_neg, div_zero, last_step;
  logic [DATA_W-1:0]   a_mag, b_mag;
  logic [DATA_W:0]     add_sum, mul_sum, shifted, diff;
  logic [DATA_W-1:0]   step_hi, step_lo;
  logic [2*DATA_W-1:0] prod, fix_res;

  // Operand magnitudes; the bare negation of the most negative value is already its magnitude.
  always_comb begin
    signed_op = ~op[0];
    a_neg     = signed_op & src_a[DATA_W-1];
    b_neg     = signed_op & src_b[DATA_W-1];
    a_mag     = a_neg ? -src_a : src_a;
    b_mag     = b_neg ? -src_b : src_b;
    div_zero  = op[1] & (src_b == '0);
    last_step = (cnt == CNT_W'(DATA_W - 1));
  end

  always_comb begin
    add_sum = {1'b0, acc_hi} + {1'b0, opnd_b};
    mul_sum = acc_lo[0] ? add_sum : {1'b0, acc_hi};
    shifted = {acc_hi, acc_lo[DATA_W-1]};
    diff    = shifted - {1'b0, opnd_b};
    if (is_div) begin
      if (!diff[DATA_W]) begin
        step_hi = diff[DATA_W-1:0];
        step_lo = {acc_lo[DATA_W-2:0], 1'b1};
      end else begin
        step_hi = shifted[DATA_W-1:0];
        step_lo = {acc_lo[DATA_W-2:0], 1'b0};
      end
    end else begin
      step_hi = mul_sum[DATA_W:1];
      step_lo = {mul_sum[0], acc_lo[DATA_W-1:1]};
    end
    prod = {step_hi, step_lo};
    if (is_div)
      fix_res = {(sign_r ? -step_hi : step_hi), (sign_q ? -step_lo : step_lo)};
    else
      fix_res = sign_q ? -prod : prod;
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state   = state;
    busy         = 1'b0;
    stall_req    = 1'b0;
    result_valid = 1'b0;
    case (state)
      IDLE: begin
        if (start && !flush) next_state = div_zero ? DONE : BUSY;
        stall_req = start & ~flush;
      end
      BUSY: begin
        if (flush)          next_state = IDLE;
        else if (last_step) next_state = DONE;
        stall_req = ~flush;
        busy      = 1'b1;
      end
      DONE: begin
        next_state   = IDLE;
        result_valid = ~flush;
        busy         = 1'b1;
      end
      default: next_state = IDLE;
    endcase
    if (!rst) begin
      busy         = 1'b0;
      stall_req    = 1'b0;
      result_valid = 1'b0;
    end
  end

  // For MUL the multiplier shifts through acc_lo and the multiplicand is added;
  // for DIV the dividend shifts out of acc_lo into the partial remainder in acc_hi.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd_b <= '0;
      is_div <= 1'b0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !flush) begin
            if (div_zero) begin
              result <= {src_a, {DATA_W{1'b1}}};
            end else begin
              cnt    <= '0;
              acc_hi <= '0;
              acc_lo <= op[1] ? a_mag : b_mag;
              opnd_b <= op[1] ? b_mag : a_mag;
              is_div <= op[1];
              sign_q <= a_neg ^ b_neg;
              sign_r <= a_neg;
            end
          end
        end
        BUSY: begin
          if (!flush) begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            cnt    <= cnt + CNT_W'(1);
            if (last_step) result <= fix_res;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
